// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit/receive state encoding.
package uart_pkg;

    localparam int UART_DEFAULT_BAUD_DIV = 10416;
    localparam int UART_DATA_BITS        = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake plus serial line of the UART transmitter; master feeds bytes, slave is the transmitter.
interface uart_tx_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] tx_data;
    logic                                tx_valid;
    logic                                tx_ready;
    logic                                tx_port;
    logic                                tx_busy;

    modport master (output tx_data, output tx_valid,
                    input  tx_ready, input tx_port, input tx_busy);

    modport slave  (input  tx_data, input tx_valid,
                    output tx_ready, output tx_port, output tx_busy);

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period down-counter: strobe when it reaches zero, then reloads BAUD_DIV-1.
// load_i restarts a full period immediately; shared with the receiver.
module uart_baud_gen #(
    parameter int BAUD_DIV = 16,
    parameter int CNT_W    = $clog2(BAUD_DIV)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic strobe_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign strobe_o = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i || strobe_o) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop.
// Line goes low one cycle after accept; each bit lasts BAUD_DIV cycles; no input accepted while busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter  int BAUD_DIV = UART_DEFAULT_BAUD_DIV,
    localparam int CNT_W    = $clog2(BAUD_DIV)
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    uart_tx_if.slave  bus
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e                state_q;
    logic                       tx_q;
    logic [UART_DATA_BITS-1:0]  shift_q;
    logic [2:0]                 bitno_q;
`ifdef UART_TX_PARITY_EN
    logic                       par_q;
`endif

    logic accept;
    logic strobe;

    assign bus.tx_ready = (state_q == IDLE);
    assign bus.tx_busy  = (state_q != IDLE);
    assign bus.tx_port  = tx_q;
    assign accept       = bus.tx_valid && (state_q == IDLE);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baud (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .load_i   (accept),
        .strobe_o (strobe)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            shift_q <= '0;
            bitno_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= bus.tx_data;
                        bitno_q <= '0;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^bus.tx_data;
`endif
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (strobe) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (strobe) begin
                        shift_q <= shift_q >> 1;
                        bitno_q <= bitno_q + 3'd1;
                        // shift_q[1] is the bit that becomes LSB after this shift
                        if (bitno_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q    <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (strobe) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (strobe) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=16: table of frames plus idle and async-reset sequences.
module tb_uart_tx;

    localparam int B = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit i = i-th bit on the line: start, d0..d7, stop
        logic       par;
        logic       hold;   // keep tx_valid high so the next vector goes back-to-back
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    uart_tx_if bus ();

    uart_tx #(.BAUD_DIV(B)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int b);
`ifdef UART_TX_PARITY_EN
        if (b < 9)       return v.frame[b];
        else if (b == 9) return v.par;
        else             return v.frame[9];
`else
        return v.frame[b];
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the frame has finished.
    task automatic send(input vec_t v);
        int wait_cnt;
        int bad;
        bus.tx_data  = v.data;
        bus.tx_valid = 1'b1;
        wait_cnt = 0;
        while (!bus.tx_ready && wait_cnt < 20 * B) begin
            @(negedge sys_clk);
            wait_cnt++;
        end
        if (!bus.tx_ready) begin
            check("ready_timeout", 32'(bus.tx_ready), 32'd1);
            return;
        end
        @(posedge sys_clk);
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int c = 0; c < B; c++) begin
                @(negedge sys_clk);
                if (b == 0 && c == 0) begin
                    check("ready_after_accept", 32'(bus.tx_ready), 32'd0);
                    check("busy_after_accept", 32'(bus.tx_busy), 32'd1);
                    bus.tx_valid = v.hold;
                    bus.tx_data  = ~v.data;
                end
                if (bus.tx_port !== exp_bit(v, b)) bad++;
            end
            check($sformatf("bit%0d_of_%02h_mismatched_cycles", b, v.data), 32'(bad), 32'd0);
        end
        check("ready_last_stop_cycle", 32'(bus.tx_ready), 32'd0);
        @(negedge sys_clk);
        check("ready_after_frame", 32'(bus.tx_ready), 32'd1);
        check("busy_after_frame", 32'(bus.tx_busy), 32'd0);
        check("idle_gap_line", 32'(bus.tx_port), 32'd1);
    endtask

    vec_t vecs [9];

    initial begin
        int bad;
        vecs[0] = '{8'h55, 10'b1010101010, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 10'b1101000110, 1'b0, 1'b1};
        vecs[2] = '{8'h0F, 10'b1000011110, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 10'b1000000000, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 10'b1111111110, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 10'b1010110100, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 10'b1100000010, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 10'b1000001110, 1'b1, 1'b0};
        vecs[8] = '{8'h03, 10'b1000000110, 1'b0, 1'b0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        #12;
        check("reset_port", 32'(bus.tx_port), 32'd1);
        check("reset_ready", 32'(bus.tx_ready), 32'd1);
        check("reset_busy", 32'(bus.tx_busy), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (bus.tx_port !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
        end
        check("idle_100_bad_cycles", 32'(bad), 32'd0);

        for (int i = 0; i < 9; i++) send(vecs[i]);

        // Asynchronous reset in the middle of the data bits of 0x00.
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus.tx_valid = 1'b0;
        repeat (3 * B) @(negedge sys_clk);
        check("pre_reset_line_low", 32'(bus.tx_port), 32'd0);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_reset_port", 32'(bus.tx_port), 32'd1);
        check("async_reset_ready", 32'(bus.tx_ready), 32'd1);
        check("async_reset_busy", 32'(bus.tx_busy), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12 * B; i++) begin
            @(negedge sys_clk);
            if (bus.tx_port !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
        end
        check("no_retransmit_bad_cycles", 32'(bad), 32'd0);
        check("ready_after_reset", 32'(bus.tx_ready), 32'd1);

        send(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
